// File: rtl/seg7_pkg.sv
//------------------------------------------------------------------------------
// Module  : seg7_pkg
// Brief   : Segment encodings and nibble-to-segment lookup for seg7_scan_driver.
// Revision: 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package seg7_pkg;

  // Segment order is a..g, with a in the leftmost bit position.
  localparam logic [0:6] SEG_BLANK = 7'b0000000;

  localparam logic [0:6] SEG_TABLE [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  function automatic logic [0:6] seg_code(input logic [3:0] nibble, input logic hex_mode);
    logic [0:6] code;
    code = SEG_TABLE[nibble];
    if (nibble > 4'd9 && !hex_mode) begin
      code = SEG_BLANK;
    end
    return code;
  endfunction

endpackage

`default_nettype wire

// File: rtl/seg7_decode.sv
//------------------------------------------------------------------------------
// Module  : seg7_decode
// Brief   : Combinational nibble to 7-segment decoder (BCD or hex).
// Revision: 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module seg7_decode
  import seg7_pkg::*;
#(
  parameter int HEX = 1
) (
  input  logic [3:0] nibble,
  output logic [0:6] seg
);

  assign seg = seg_code(nibble, HEX != 0);

endmodule

`default_nettype wire

// File: rtl/seg7_scan_driver.sv
//------------------------------------------------------------------------------
// Module  : seg7_scan_driver
// Brief   : Time-multiplexed common-anode 7-segment driver with double-buffered
//           value, blanking and leading-zero suppression.
// Revision: 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int DIV    = 1000,
  parameter int HEX    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic                  blank_l,
  input  logic                  lz_en,
  output logic [0:6]            seg,
  output logic [DIGITS-1:0]     dig_l,
  output logic                  frame
);

  localparam int PC_W  = $clog2(DIV);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PC_W-1:0]  PC_MAX  = PC_W'(DIV - 1);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(DIGITS - 1);

  logic [PC_W-1:0]       pc_q, pc_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [4*DIGITS-1:0]   pend_q, pend_d;
  logic [4*DIGITS-1:0]   act_q, act_d;
  logic                  pend_v_q, pend_v_d;
  logic [0:6]            seg_q, seg_d;
  logic [DIGITS-1:0]     dig_l_q, dig_l_d;
  logic                  frame_q, frame_d;

  logic                  tick;
  logic                  boundary;
  logic [DIGITS-1:0]     hi_zero;
  logic                  zero_run;
  logic [3:0]            nib_sel;
  logic                  suppress;
  logic [DIGITS-1:0]     dig_sel_l;
  logic [0:6]            dec_seg;

  always_comb begin
    tick     = (pc_q == PC_MAX);
    boundary = tick && (idx_q == IDX_MAX);
    pc_d     = tick ? '0 : pc_q + 1'b1;
    idx_d    = idx_q;
    if (tick) begin
      idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
    end
  end

  // A load coinciding with a boundary bypasses pend and lands in act directly.
  always_comb begin
    pend_d   = pend_q;
    pend_v_d = pend_v_q;
    act_d    = act_q;
    if (load) begin
      pend_d   = value;
      pend_v_d = 1'b1;
    end
    if (boundary) begin
      if (load) begin
        act_d    = value;
        pend_v_d = 1'b0;
      end else if (pend_v_q) begin
        act_d    = pend_q;
        pend_v_d = 1'b0;
      end
    end
  end

  // Outputs are built from next-state idx/act so the pins line up with the
  // frame pulse: the frame cycle already shows digit 0 of the new value.
  always_comb begin
    zero_run  = 1'b1;
    hi_zero   = '0;
    nib_sel   = 4'h0;
    suppress  = 1'b0;
    dig_sel_l = '1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_run   = zero_run & (act_d[4*i +: 4] == 4'h0);
      hi_zero[i] = zero_run;
    end
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_d == IDX_W'(i)) begin
        nib_sel      = act_d[4*i +: 4];
        suppress     = lz_en && (i != 0) && hi_zero[i];
        dig_sel_l[i] = 1'b0;
      end
    end
  end

  seg7_decode #(
    .HEX (HEX)
  ) u_decode (
    .nibble (nib_sel),
    .seg    (dec_seg)
  );

  always_comb begin
    seg_d   = (!blank_l || suppress) ? SEG_BLANK : dec_seg;
    dig_l_d = blank_l ? dig_sel_l : '1;
    frame_d = boundary;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q     <= '0;
      idx_q    <= '0;
      pend_q   <= '0;
      act_q    <= '0;
      pend_v_q <= 1'b0;
      seg_q    <= SEG_BLANK;
      dig_l_q  <= '1;
      frame_q  <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      idx_q    <= idx_d;
      pend_q   <= pend_d;
      act_q    <= act_d;
      pend_v_q <= pend_v_d;
      seg_q    <= seg_d;
      dig_l_q  <= dig_l_d;
      frame_q  <= frame_d;
    end
  end

  assign seg   = seg_q;
  assign dig_l = dig_l_q;
  assign frame = frame_q;

endmodule

`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
//------------------------------------------------------------------------------
// Module  : tb_seg7_scan_driver
// Brief   : Directed self-checking bench for seg7_scan_driver (DIGITS=4, DIV=4).
// Revision: 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_seg7_scan_driver;

  localparam int DIGITS = 4;
  localparam int DIV    = 4;
  localparam logic [3:0] DIG_EXP [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  logic        clk;
  logic        rst;
  logic        load;
  logic [15:0] value;
  logic        blank_l;
  logic        lz_en;
  logic [0:6]  seg_h, seg_n;
  logic [3:0]  dig_h, dig_n;
  logic        frame_h, frame_n;

  int errors = 0;
  int checks = 0;

  logic [6:0] obs_seg  [4];
  logic [6:0] obs_segn [4];
  logic [3:0] obs_dig  [4];
  logic [3:0] obs_dign [4];
  logic       obs_frame_next;
  int         obs_frame_mid;

  seg7_scan_driver #(.DIGITS(DIGITS), .DIV(DIV), .HEX(1)) u_dut (
    .clk (clk), .rst (rst), .load (load), .value (value),
    .blank_l (blank_l), .lz_en (lz_en),
    .seg (seg_h), .dig_l (dig_h), .frame (frame_h)
  );

  seg7_scan_driver #(.DIGITS(DIGITS), .DIV(DIV), .HEX(0)) u_dut_nohex (
    .clk (clk), .rst (rst), .load (load), .value (value),
    .blank_l (blank_l), .lz_en (lz_en),
    .seg (seg_n), .dig_l (dig_n), .frame (frame_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [15:0] v);
    load  = 1'b1;
    value = v;
    step();
    load  = 1'b0;
  endtask

  task automatic wait_frame(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (frame_h !== 1'b1 && n < 200);
    if (frame_h !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL wait_frame: got no frame pulse expected one within 200 cycles");
    end
  endtask

  // Samples each digit slot of one frame; caller must be in the frame cycle.
  task automatic scan_frame();
    obs_frame_mid = 0;
    for (int k = 0; k < 16; k++) begin
      if (k % 4 == 0) begin
        obs_seg[k/4]  = seg_h;
        obs_segn[k/4] = seg_n;
        obs_dig[k/4]  = dig_h;
        obs_dign[k/4] = dig_n;
      end
      if (k != 0 && frame_h === 1'b1) obs_frame_mid++;
      step();
    end
    obs_frame_next = frame_h;
  endtask

  task automatic test_reset();
    rst = 1'b1; load = 1'b0; value = '0; blank_l = 1'b1; lz_en = 1'b0;
    repeat (3) step();
    checks++;
    if (seg_h !== 7'b0000000) begin
      errors++; $display("FAIL reset_seg: got %b expected 0000000", seg_h);
    end
    checks++;
    if (dig_h !== 4'b1111) begin
      errors++; $display("FAIL reset_dig: got %b expected 1111", dig_h);
    end
    checks++;
    if (frame_h !== 1'b0) begin
      errors++; $display("FAIL reset_frame: got %b expected 0", frame_h);
    end
  endtask

  task automatic test_idle();
    int n;
    rst = 1'b0;
    step();
    checks++;
    if (seg_h !== 7'b1111110 || dig_h !== 4'b1110 || frame_h !== 1'b0) begin
      errors++;
      $display("FAIL first_cycle: got seg=%b dig=%b frame=%b expected 1111110 1110 0",
               seg_h, dig_h, frame_h);
    end
    wait_frame(n);
    checks++;
    if (n != 15) begin
      errors++; $display("FAIL idle_first_frame: got %0d cycles expected 15", n);
    end
    scan_frame();
    for (int j = 0; j < 4; j++) begin
      checks++;
      if (obs_dig[j] !== DIG_EXP[j] || obs_seg[j] !== 7'b1111110) begin
        errors++;
        $display("FAIL idle_slot%0d: got dig=%b seg=%b expected %b 1111110",
                 j, obs_dig[j], obs_seg[j], DIG_EXP[j]);
      end
    end
    checks++;
    if (obs_frame_next !== 1'b1 || obs_frame_mid != 0) begin
      errors++;
      $display("FAIL idle_frame_period: got next=%b mid=%0d expected 1 0",
               obs_frame_next, obs_frame_mid);
    end
  endtask

  task automatic test_load_hex();
    int bad;
    logic [6:0] exp_h [4];
    logic [6:0] exp_n [4];
    exp_h = '{7'b1000111, 7'b1110111, 7'b1101101, 7'b0110000};
    exp_n = '{7'b0000000, 7'b0000000, 7'b1101101, 7'b0110000};
    repeat (5) step();
    do_load(16'h12AF);
    bad = 0;
    for (int k = 6; k < 16; k++) begin
      if (seg_h !== 7'b1111110 || frame_h !== 1'b0) bad++;
      step();
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL load_midframe_stable: got %0d changed cycles expected 0", bad);
    end
    checks++;
    if (frame_h !== 1'b1 || frame_n !== 1'b1) begin
      errors++; $display("FAIL load_frame: got %b/%b expected 1/1", frame_h, frame_n);
    end
    scan_frame();
    for (int j = 0; j < 4; j++) begin
      checks++;
      if (obs_seg[j] !== exp_h[j]) begin
        errors++; $display("FAIL hex_digit%0d: got %b expected %b", j, obs_seg[j], exp_h[j]);
      end
      checks++;
      if (obs_segn[j] !== exp_n[j] || obs_dign[j] !== DIG_EXP[j]) begin
        errors++;
        $display("FAIL nohex_digit%0d: got seg=%b dig=%b expected %b %b",
                 j, obs_segn[j], obs_dign[j], exp_n[j], DIG_EXP[j]);
      end
    end
  endtask

  task automatic test_lz();
    int n;
    logic [6:0] exp5 [4];
    logic [6:0] exp0 [4];
    exp5 = '{7'b1011011, 7'b0000000, 7'b0000000, 7'b0000000};
    exp0 = '{7'b1111110, 7'b0000000, 7'b0000000, 7'b0000000};
    lz_en = 1'b1;
    do_load(16'h0005);
    wait_frame(n);
    scan_frame();
    for (int j = 0; j < 4; j++) begin
      checks++;
      if (obs_seg[j] !== exp5[j] || obs_dig[j] !== DIG_EXP[j]) begin
        errors++;
        $display("FAIL lz5_digit%0d: got seg=%b dig=%b expected %b %b",
                 j, obs_seg[j], obs_dig[j], exp5[j], DIG_EXP[j]);
      end
    end
    do_load(16'h0000);
    wait_frame(n);
    scan_frame();
    for (int j = 0; j < 4; j++) begin
      checks++;
      if (obs_seg[j] !== exp0[j]) begin
        errors++; $display("FAIL lz0_digit%0d: got %b expected %b", j, obs_seg[j], exp0[j]);
      end
    end
    lz_en = 1'b0;
  endtask

  task automatic test_back_to_back();
    int n;
    step();
    do_load(16'h1111);
    repeat (2) step();
    do_load(16'h2222);
    wait_frame(n);
    scan_frame();
    for (int j = 0; j < 4; j++) begin
      checks++;
      if (obs_seg[j] !== 7'b1101101) begin
        errors++; $display("FAIL last_load_wins%0d: got %b expected 1101101", j, obs_seg[j]);
      end
    end
    repeat (15) step();
    do_load(16'h3333);
    checks++;
    if (frame_h !== 1'b1) begin
      errors++; $display("FAIL coincident_frame: got %b expected 1", frame_h);
    end
    scan_frame();
    for (int j = 0; j < 4; j++) begin
      checks++;
      if (obs_seg[j] !== 7'b1111001) begin
        errors++; $display("FAIL coincident_load%0d: got %b expected 1111001", j, obs_seg[j]);
      end
    end
  endtask

  task automatic test_blank_rst();
    int n;
    int bad;
    do_load(16'h4444);
    blank_l = 1'b0;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (seg_h !== 7'b0000000 || dig_h !== 4'b1111) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL blanking: got %0d lit cycles expected 0", bad);
    end
    rst = 1'b1; load = 1'b1; value = 16'h5555; blank_l = 1'b1;
    step();
    checks++;
    if (seg_h !== 7'b0000000 || dig_h !== 4'b1111 || frame_h !== 1'b0) begin
      errors++;
      $display("FAIL midframe_rst: got seg=%b dig=%b frame=%b expected 0000000 1111 0",
               seg_h, dig_h, frame_h);
    end
    rst = 1'b0; load = 1'b0;
    step();
    checks++;
    if (seg_h !== 7'b1111110 || dig_h !== 4'b1110) begin
      errors++; $display("FAIL post_rst_first: got seg=%b dig=%b expected 1111110 1110", seg_h, dig_h);
    end
    wait_frame(n);
    checks++;
    if (n != 15) begin
      errors++; $display("FAIL post_rst_phase: got %0d cycles expected 15", n);
    end
    scan_frame();
    for (int j = 0; j < 4; j++) begin
      checks++;
      if (obs_seg[j] !== 7'b1111110 || obs_dig[j] !== DIG_EXP[j]) begin
        errors++;
        $display("FAIL pend_discarded%0d: got seg=%b dig=%b expected 1111110 %b",
                 j, obs_seg[j], obs_dig[j], DIG_EXP[j]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_load_hex();
    test_lz();
    test_back_to_back();
    test_blank_rst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
